// File: rtl/axi_rdata_to_wb_channel_pkg.sv
// Shared bridge definitions for the AXI R channel to Wishbone read completion path.
package axi_rdata_to_wb_channel_pkg;

    // AXI RRESP encodings
    localparam logic [1:0] RRESP_OKAY   = 2'b00;
    localparam logic [1:0] RRESP_EXOKAY = 2'b01;
    localparam logic [1:0] RRESP_SLVERR = 2'b10;
    localparam logic [1:0] RRESP_DECERR = 2'b11;

    // Default number of WAIT_DATA cycles before a read is declared lost
    localparam int DEFAULT_TIMEOUT_CYCLES = 256;

    // Read completion states
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_DATA = 3'd1,
        ST_DRAIN     = 3'd2,
        ST_RESPOND   = 3'd3,
        ST_ORPHAN    = 3'd4
    } rd_state_e;

    // True for the two error responses (SLVERR, DECERR)
    function automatic logic rresp_is_err(input logic [1:0] rresp);
        return (rresp == RRESP_SLVERR) || (rresp == RRESP_DECERR);
    endfunction

endpackage

// File: rtl/axi_rdata_to_wb_channel.sv
// AXI R channel to Wishbone read completion. Arms on the address stage's
// accept pulse, takes the first R beat's data, drains any extra beats and
// returns a single registered wb_ack or wb_err. Covers error responses, ID
// mismatch, Wishbone abort and a response timeout (lost reads are drained
// in ORPHAN without a second strobe).
module axi_rdata_to_wb_channel
    import axi_rdata_to_wb_channel_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ID_WIDTH       = 4,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    input  logic                  addr_accepted,
    input  logic [ID_WIDTH-1:0]   expected_id,
    input  logic                  wb_cyc,
    output logic [DATA_WIDTH-1:0] wb_dat_o,
    output logic                  wb_ack,
    output logic                  wb_err,
    output logic                  busy,
    output logic                  timeout,
    output logic                  proto_err,
    input  logic [ID_WIDTH-1:0]   axi_rid,
    input  logic [DATA_WIDTH-1:0] axi_rdata,
    input  logic [1:0]            axi_rresp,
    input  logic                  axi_rlast,
    input  logic                  axi_rvalid,
    output logic                  axi_rready
);

    // Counter must be able to hold TIMEOUT_CYCLES itself; keep one bit when disabled
    localparam int CNT_W  = (TIMEOUT_CYCLES > 32'sd0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam bit TMO_EN = (TIMEOUT_CYCLES > 32'sd0);

    rd_state_e             state_r;
    logic [ID_WIDTH-1:0]   id_r;
    logic                  err_r;
    logic                  abort_r;
    logic [CNT_W-1:0]      cnt_r;
    logic [DATA_WIDTH-1:0] dat_r;
    logic                  ack_r;
    logic                  werr_r;
    logic                  timeout_r;
    logic                  proto_r;

    logic                  rready_s;
    logic                  busy_s;
    logic                  beat_s;
    logic                  beat_err_s;
    logic                  err_next_s;
    logic                  abort_next_s;
    logic [CNT_W-1:0]      cnt_next_s;
    logic                  tmo_hit_s;
    logic                  proto_s;

    // Ready and busy are pure state decodes so ready never depends on rvalid
    always_comb begin
        rready_s = 1'b0;
        busy_s   = 1'b1;
        case (state_r)
            ST_IDLE: begin
                rready_s = 1'b0;
                busy_s   = 1'b0;
            end
            ST_WAIT_DATA, ST_DRAIN, ST_ORPHAN: begin
                rready_s = 1'b1;
                busy_s   = 1'b1;
            end
            ST_RESPOND: begin
                rready_s = 1'b0;
                busy_s   = 1'b1;
            end
            default: begin
                rready_s = 1'b0;
                busy_s   = 1'b1;
            end
        endcase
    end

    // Beat qualification, sticky-flag next values, timeout and protocol-error detection
    always_comb begin
        beat_s       = axi_rvalid && rready_s;
        beat_err_s   = rresp_is_err(axi_rresp) || (axi_rid != id_r);
        err_next_s   = err_r || (beat_s && beat_err_s);
        abort_next_s = abort_r || !wb_cyc;
        cnt_next_s   = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        if (TMO_EN) begin
            tmo_hit_s = (cnt_next_s == CNT_W'(TIMEOUT_CYCLES));
        end else begin
            tmo_hit_s = 1'b0;
        end
        proto_s = (addr_accepted && (state_r != ST_IDLE)) ||
                  (axi_rvalid && (state_r == ST_IDLE));
    end

    // Completion FSM with registered strobes, data and sticky error/abort flags
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_r   <= ST_IDLE;
            id_r      <= {ID_WIDTH{1'b0}};
            err_r     <= 1'b0;
            abort_r   <= 1'b0;
            cnt_r     <= {CNT_W{1'b0}};
            dat_r     <= {DATA_WIDTH{1'b0}};
            ack_r     <= 1'b0;
            werr_r    <= 1'b0;
            timeout_r <= 1'b0;
            proto_r   <= 1'b0;
        end else begin
            ack_r     <= 1'b0;
            werr_r    <= 1'b0;
            timeout_r <= 1'b0;
            proto_r   <= proto_s;
            case (state_r)
                ST_IDLE: begin
                    if (addr_accepted) begin
                        id_r    <= expected_id;
                        err_r   <= 1'b0;
                        abort_r <= 1'b0;
                        cnt_r   <= {CNT_W{1'b0}};
                        state_r <= ST_WAIT_DATA;
                    end
                end
                ST_WAIT_DATA: begin
                    cnt_r   <= cnt_next_s;
                    abort_r <= abort_next_s;
                    if (beat_s) begin
                        // A beat always wins over a timeout in the same cycle
                        dat_r <= axi_rdata;
                        err_r <= err_next_s;
                        if (axi_rlast) begin
                            ack_r   <= !abort_next_s && !err_next_s;
                            werr_r  <= !abort_next_s && err_next_s;
                            state_r <= ST_RESPOND;
                        end else begin
                            state_r <= ST_DRAIN;
                        end
                    end else if (tmo_hit_s) begin
                        // The error is reported now; the late data is drained later
                        timeout_r <= 1'b1;
                        werr_r    <= wb_cyc;
                        state_r   <= ST_ORPHAN;
                    end
                end
                ST_DRAIN: begin
                    abort_r <= abort_next_s;
                    err_r   <= err_next_s;
                    if (beat_s && axi_rlast) begin
                        ack_r   <= !abort_next_s && !err_next_s;
                        werr_r  <= !abort_next_s && err_next_s;
                        state_r <= ST_RESPOND;
                    end
                end
                ST_RESPOND: begin
                    state_r <= ST_IDLE;
                end
                ST_ORPHAN: begin
                    if (beat_s && axi_rlast) begin
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign wb_dat_o   = dat_r;
    assign wb_ack     = ack_r;
    assign wb_err     = werr_r;
    assign timeout    = timeout_r;
    assign proto_err  = proto_r;
    assign busy       = busy_s;
    assign axi_rready = rready_s;

endmodule
